// File: rtl/pulse_sync_scheduler.sv
// pulse_sync_scheduler
// Shares one toggle-based pulse synchronizer channel between NUM_REQ event
// sources on the source clock. Each requester has a saturating pending
// counter. A round-robin arbiter picks one requester at a time. Every issued
// pulse is followed by GAP_CYCLES idle cycles so that the destination domain
// can resolve each toggle and sample the quasi-static ID.
module pulse_sync_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int CNT_W      = 4,
  parameter int GAP_CYCLES = 6,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_pulse_in,
  input  logic               enable,
  input  logic               ovrflw_clr,
  output logic               sync_pulse_out,
  output logic [ID_W-1:0]    sync_id_out,
  output logic [NUM_REQ-1:0] pend_vec_out,
  output logic [NUM_REQ-1:0] ovrflw_out
);

  localparam int               GAP_W    = $clog2(GAP_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_GAP  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt [NUM_REQ];
  logic [CNT_W-1:0]   w_cnt_nxt [NUM_REQ];
  logic [NUM_REQ-1:0] r_ovf;
  logic [NUM_REQ-1:0] w_ovf_nxt;
  logic [NUM_REQ-1:0] r_pend;
  logic               r_pulse;
  logic [ID_W-1:0]    r_id;
  logic [ID_W-1:0]    r_ptr;
  logic [GAP_W-1:0]   r_gap;
  logic               w_any;
  logic               w_grant;
  logic [ID_W-1:0]    w_pick;
  logic [NUM_REQ-1:0] w_gnt_vec;

  // Index base+off wrapped modulo NUM_REQ.
  function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int off);
    int sum;
    sum = (int'(base) + off) % NUM_REQ;
    return ID_W'(sum);
  endfunction

  // Round-robin search over registered counts, starting at the pointer.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_any && (r_cnt[rr_idx(r_ptr, k)] != '0)) begin
        w_any  = 1'b1;
        w_pick = rr_idx(r_ptr, k);
      end else begin
        w_any = w_any;
      end
    end
  end

  // FSM next state and grant decision; a grant is only possible in IDLE or on the last GAP cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (enable && w_any) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_GAP;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (r_gap != '0) begin
          w_state_nxt = ST_GAP;
        end else if (enable && w_any) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_GAP;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Per-requester next count and sticky overflow; a new overflow beats a clear.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_gnt_vec[i] = w_grant && (w_pick == ID_W'(i));
      w_cnt_nxt[i] = r_cnt[i];
      w_ovf_nxt[i] = r_ovf[i] & ~ovrflw_clr;
      if (req_pulse_in[i] && !w_gnt_vec[i]) begin
        if (r_cnt[i] == CNT_MAX) begin
          w_ovf_nxt[i] = 1'b1;
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end else if (w_gnt_vec[i] && !req_pulse_in[i]) begin
        w_cnt_nxt[i] = r_cnt[i] - {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        w_cnt_nxt[i] = r_cnt[i];
      end
    end
  end

  // State, counters, gap timer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ovf   <= '0;
      r_pend  <= '0;
      r_pulse <= 1'b0;
      r_id    <= '0;
      r_ptr   <= '0;
      r_gap   <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_ovf   <= w_ovf_nxt;
      r_pulse <= w_grant;
      for (int i = 0; i < NUM_REQ; i++) begin
        r_cnt[i]  <= w_cnt_nxt[i];
        r_pend[i] <= (w_cnt_nxt[i] != '0);
      end
      if (w_grant) begin
        r_id  <= w_pick;
        r_ptr <= rr_idx(w_pick, 1);
        r_gap <= GAP_LOAD;
      end else if (r_gap != '0) begin
        r_gap <= r_gap - {{(GAP_W-1){1'b0}}, 1'b1};
      end else begin
        r_gap <= r_gap;
      end
    end
  end

  assign sync_pulse_out = r_pulse;
  assign sync_id_out    = r_id;
  assign pend_vec_out   = r_pend;
  assign ovrflw_out     = r_ovf;

endmodule
